// File: rtl/cpu_io_pkg.sv
// Shared CPU IO definitions: datapath word width and the output-word type, so the CPU,
// the output buffer and benches all agree on the word format.
package cpu_io_pkg;

    localparam int IO_WIDTH = 36;

    typedef logic [IO_WIDTH-1:0] io_word_t;

endpackage : cpu_io_pkg

// File: rtl/output_fifo_mem.sv
// Storage array for the CPU output FIFO: one synchronous write port, one asynchronous read
// port, and no reset, because the contents only matter while the read pointer covers them.
module output_fifo_mem #(
    parameter int WIDTH    = 36,
    parameter int DEPTH    = 8,
    parameter int PTRWIDTH = 3
) (
    input  logic                clock,
    input  logic                we,
    input  logic [PTRWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [PTRWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: the top qualifies every write, so no other gating is needed here.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : output_fifo_mem

// File: rtl/cpu_output_buffer.sv
// First-word-fall-through capture buffer for CPU output words, plus a sticky drop flag
// and a saturating count of the words it has accepted.
module cpu_output_buffer
    import cpu_io_pkg::*;
#(
    parameter int WIDTH      = IO_WIDTH,
    parameter int DEPTH      = 8,
    parameter int PTRWIDTH   = 3,
    parameter int COUNTWIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  outFlag,
    input  logic [WIDTH-1:0]      out,
    output logic                  outValid,
    output logic [WIDTH-1:0]      outData,
    input  logic                  outReady,
    output logic                  full,
    output logic                  empty,
    output logic [PTRWIDTH:0]     level,
    output logic                  overflow,
    input  logic                  clearOverflow,
    output logic [COUNTWIDTH-1:0] wordCount
);

    logic [PTRWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTRWIDTH:0]     level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [COUNTWIDTH-1:0] word_count_q, word_count_d;

    logic             empty_s, full_s;
    logic             push_s, pop_s, drop_s;
    logic [WIDTH-1:0] rdata_s;

    // Status is decoded from the level register only, so outFlag never reaches outValid.
    assign empty_s = (level_q == {(PTRWIDTH+1){1'b0}});
    assign full_s  = (level_q == (PTRWIDTH+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a full buffer can still accept a word.
    assign pop_s  = !empty_s & outReady;
    assign push_s = outFlag & (!full_s | pop_s);
    assign drop_s = outFlag & full_s & !pop_s;

    output_fifo_mem #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .PTRWIDTH (PTRWIDTH)
    ) u_mem (
        .clock (clock),
        .we    (push_s),
        .waddr (wr_ptr_q),
        .wdata (out),
        .raddr (rd_ptr_q),
        .rdata (rdata_s)
    );

    // Next-state for pointers, level, the sticky drop flag and the accepted-word counter.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTRWIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTRWIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (PTRWIDTH+1)'(1);
            2'b01:   level_d = level_q - (PTRWIDTH+1)'(1);
            default: level_d = level_q;
        endcase

        // A fresh drop outranks a simultaneous clear so no loss goes unreported.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clearOverflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (push_s && (word_count_q != {COUNTWIDTH{1'b1}})) begin
            word_count_d = word_count_q + COUNTWIDTH'(1);
        end else begin
            word_count_d = word_count_q;
        end
    end

    // State registers; reset discards every held word by clearing the pointers and level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= {PTRWIDTH{1'b0}};
            rd_ptr_q     <= {PTRWIDTH{1'b0}};
            level_q      <= {(PTRWIDTH+1){1'b0}};
            overflow_q   <= 1'b0;
            word_count_q <= {COUNTWIDTH{1'b0}};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
        end
    end

    assign outValid  = !empty_s;
    assign outData   = empty_s ? {WIDTH{1'b0}} : rdata_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign wordCount = word_count_q;

endmodule : cpu_output_buffer

// File: tb/tb_cpu_output_buffer.sv
// Directed bench for cpu_output_buffer: a default instance plus a 4-bit counter instance
// for the saturation scenario; inputs change 1ns after the rising edge.
module tb_cpu_output_buffer;
    import cpu_io_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        outFlag, outReady, clearOverflow;
    io_word_t    out;
    logic        outValid, full, empty, overflow;
    io_word_t    outData;
    logic [3:0]  level;
    logic [15:0] wordCount;

    logic        s_outFlag, s_outReady, s_clearOverflow;
    io_word_t    s_out;
    logic        s_outValid, s_full, s_empty, s_overflow;
    io_word_t    s_outData;
    logic [3:0]  s_level;
    logic [3:0]  s_wordCount;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    cpu_output_buffer dut (
        .clock(clock), .reset(reset), .outFlag(outFlag), .out(out),
        .outValid(outValid), .outData(outData), .outReady(outReady),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .clearOverflow(clearOverflow), .wordCount(wordCount)
    );

    cpu_output_buffer #(.COUNTWIDTH(4)) dut_sat (
        .clock(clock), .reset(reset), .outFlag(s_outFlag), .out(s_out),
        .outValid(s_outValid), .outData(s_outData), .outReady(s_outReady),
        .full(s_full), .empty(s_empty), .level(s_level), .overflow(s_overflow),
        .clearOverflow(s_clearOverflow), .wordCount(s_wordCount)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        outFlag = 1'b0; outReady = 1'b0; clearOverflow = 1'b0; out = '0;
        s_outFlag = 1'b0; s_outReady = 1'b0; s_clearOverflow = 1'b0; s_out = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        outFlag = 1'b1;
        out = 36'h5;
        step();
        step();
        tests_run++;
        if ({outValid, level, wordCount, overflow, empty, full, outData} !== {1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b0, 36'h0}) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b level=%0d wc=%0d ovf=%b empty=%b full=%b data=%h, required 0 0 0 0 1 0 0",
                     outValid, level, wordCount, overflow, empty, full, outData);
        end
        reset = 1'b1;
        tests_run++;
        if (outValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_no_bypass: outValid=%b required 0", outValid);
        end
        step();
        outFlag = 1'b0;
        tests_run++;
        if ({outValid, outData, level, wordCount} !== {1'b1, 36'h5, 4'd1, 16'd1}) begin
            tests_failed++;
            $display("FAIL reset_first_push: valid=%b data=%h level=%0d wc=%0d, required 1 5 1 1",
                     outValid, outData, level, wordCount);
        end
        do_reset();
        tests_run++;
        if ({outValid, level, wordCount} !== {1'b0, 4'd0, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_discard: valid=%b level=%0d wc=%0d, required 0 0 0", outValid, level, wordCount);
        end
    endtask

    task automatic test_ordering();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            outFlag = 1'b1;
            out = 36'(i);
            step();
        end
        outFlag = 1'b0;
        tests_run++;
        if ({level, outData} !== {4'd3, 36'h1}) begin
            tests_failed++;
            $display("FAIL order_level: level=%0d data=%h, required 3 1", level, outData);
        end
        outReady = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tests_run++;
            if ({outValid, outData} !== {1'b1, 36'(i)}) begin
                tests_failed++;
                $display("FAIL order_drain%0d: valid=%b data=%h, required 1 %h", i, outValid, outData, 36'(i));
            end
            step();
        end
        tests_run++;
        if ({empty, outValid, outData} !== {1'b1, 1'b0, 36'h0}) begin
            tests_failed++;
            $display("FAIL order_empty: empty=%b valid=%b data=%h, required 1 0 0", empty, outValid, outData);
        end
    endtask

    task automatic test_empty_pop();
        outReady = 1'b1;
        step();
        step();
        tests_run++;
        if ({level, empty} !== {4'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL empty_pop_level: level=%0d empty=%b, required 0 1", level, empty);
        end
        outReady = 1'b0;
        outFlag = 1'b1;
        out = 36'h55;
        step();
        outFlag = 1'b0;
        tests_run++;
        if ({outData, level} !== {36'h55, 4'd1}) begin
            tests_failed++;
            $display("FAIL empty_pop_ptr: data=%h level=%0d, required 55 1", outData, level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            outFlag = 1'b1;
            out = 36'h10 + 36'(i);
            step();
        end
        outFlag = 1'b0;
        tests_run++;
        if ({full, level, overflow, wordCount, outData} !== {1'b1, 4'd8, 1'b1, 16'd8, 36'h10}) begin
            tests_failed++;
            $display("FAIL ovf_full: full=%b level=%0d ovf=%b wc=%0d head=%h, required 1 8 1 8 10",
                     full, level, overflow, wordCount, outData);
        end
        outFlag = 1'b1;
        out = 36'h99;
        clearOverflow = 1'b1;
        step();
        outFlag = 1'b0;
        tests_run++;
        if ({overflow, wordCount, level} !== {1'b1, 16'd8, 4'd8}) begin
            tests_failed++;
            $display("FAIL ovf_drop_beats_clear: ovf=%b wc=%0d level=%0d, required 1 8 8", overflow, wordCount, level);
        end
        step();
        clearOverflow = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        io_word_t exp_q [$];
        outFlag = 1'b1;
        outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            out = 36'h20 + 36'(k);
            tests_run++;
            if ({outData, level} !== {36'h10 + 36'(k), 4'd8}) begin
                tests_failed++;
                $display("FAIL fullpp_cycle%0d: data=%h level=%0d, required %h 8", k, outData, level, 36'h10 + 36'(k));
            end
            step();
        end
        outFlag = 1'b0;
        tests_run++;
        if ({level, overflow, wordCount} !== {4'd8, 1'b0, 16'd11}) begin
            tests_failed++;
            $display("FAIL fullpp_state: level=%0d ovf=%b wc=%0d, required 8 0 11", level, overflow, wordCount);
        end
        for (int j = 3; j < 8; j++) exp_q.push_back(36'h10 + 36'(j));
        for (int j = 0; j < 3; j++) exp_q.push_back(36'h20 + 36'(j));
        for (int j = 0; j < 8; j++) begin
            tests_run++;
            if ({outValid, outData} !== {1'b1, exp_q[j]}) begin
                tests_failed++;
                $display("FAIL fullpp_drain%0d: valid=%b data=%h, required 1 %h", j, outValid, outData, exp_q[j]);
            end
            step();
        end
        outReady = 1'b0;
        tests_run++;
        if ({empty, outData} !== {1'b1, 36'h0}) begin
            tests_failed++;
            $display("FAIL fullpp_empty: empty=%b data=%h, required 1 0", empty, outData);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        outReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            outFlag = 1'b1;
            out = 36'h100 + 36'(i);
            tests_run++;
            if (i == 0) begin
                if (outValid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stream_start: valid=%b required 0", outValid);
                end
            end else if ({outValid, outData} !== {1'b1, 36'h100 + 36'(i - 1)}) begin
                tests_failed++;
                $display("FAIL stream_word%0d: valid=%b data=%h, required 1 %h", i, outValid, outData, 36'h100 + 36'(i - 1));
            end
            tests_run++;
            if (level > 4'd1) begin
                tests_failed++;
                $display("FAIL stream_level%0d: level=%0d, required <=1", i, level);
            end
            step();
        end
        outFlag = 1'b0;
        tests_run++;
        if ({outData, wordCount} !== {36'h113, 16'd20}) begin
            tests_failed++;
            $display("FAIL stream_last: data=%h wc=%0d, required 113 20", outData, wordCount);
        end
        step();
        outReady = 1'b0;
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_empty: empty=%b required 1", empty);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        s_outReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 15) begin
                tests_run++;
                if (s_wordCount !== 4'd15) begin
                    tests_failed++;
                    $display("FAIL sat_reach: wc=%0d required 15", s_wordCount);
                end
            end
            s_outFlag = 1'b1;
            s_out = 36'h200 + 36'(i);
            step();
        end
        s_outFlag = 1'b0;
        tests_run++;
        if ({s_wordCount, s_outData} !== {4'd15, 36'h213}) begin
            tests_failed++;
            $display("FAIL sat_hold: wc=%0d data=%h, required 15 213", s_wordCount, s_outData);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_ordering();
        test_empty_pop();
        test_overflow();
        test_full_push_pop();
        test_streaming();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_cpu_output_buffer
